// File: rtl/mem_access_unit_pkg.sv
// Shared memory-op encodings, access-size decode and byte-lane helpers
// for the memory access stage.
package mem_access_unit_pkg;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    SIZE_NONE,
    SIZE_B,
    SIZE_H,
    SIZE_W
  } access_size_e;

  // Unused op codes decode as SIZE_NONE and behave like a NOP.
  function automatic access_size_e op_size(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: op_size = SIZE_B;
      MEM_LH, MEM_LHU, MEM_SH: op_size = SIZE_H;
      MEM_LW, MEM_SW:          op_size = SIZE_W;
      default:                 op_size = SIZE_NONE;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [3:0] op);
    op_is_load = (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
                 (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    op_is_store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lsb);
    case (op_size(op))
      SIZE_H:  is_misaligned = lsb[0];
      SIZE_W:  is_misaligned = |lsb;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [3:0] op, input logic [1:0] lsb);
    case (op_size(op))
      SIZE_B:  byte_enable = 4'b0001 << lsb;
      SIZE_H:  byte_enable = 4'b0011 << {lsb[1], 1'b0};
      SIZE_W:  byte_enable = 4'b1111;
      default: byte_enable = 4'b0000;
    endcase
  endfunction

  // Narrow stores replicate onto every lane so the slave picks by byte enable.
  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] d);
    case (op_size(op))
      SIZE_B:  store_data = {4{d[7:0]}};
      SIZE_H:  store_data = {2{d[15:0]}};
      SIZE_W:  store_data = d;
      default: store_data = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load data alignment: picks the addressed byte/halfword lane from the
// bus word and sign- or zero-extends it to 32 bits.
module mem_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addrLsb,
  input  logic [3:0]  i_op,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addrLsb)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addrLsb[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_op)
      MEM_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: o_data = {24'd0, w_byte};
      MEM_LH:  o_data = {{16{w_half[15]}}, w_half};
      MEM_LHU: o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage behind the load/store execute unit: drives the req/gnt/rvalid
// bus and a registered writeback beat. Define MEM_TIMEOUT_EN for the bus timeout abort and bus_err_o.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  reg_we_i,
  input  logic [4:0]            reg_waddr_i,
  input  logic [DATA_WIDTH-1:0] reg_wdata_i,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic [3:0]            bus_be_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  output logic                  wb_valid_o,
  output logic                  wb_we_o,
  output logic [4:0]            wb_waddr_o,
  output logic [DATA_WIDTH-1:0] wb_wdata_o,
  output logic                  misalign_o
`ifdef MEM_TIMEOUT_EN
  ,
  output logic                  bus_err_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RWAIT
  } state_e;

  state_e      r_state;
  logic [3:0]  r_op;
  logic [1:0]  r_addrLsb;
  logic [4:0]  r_waddr;

  logic        w_accept;
  logic        w_isMem;
  logic        w_misaligned;
  logic [31:0] w_loadData;

`ifdef MEM_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);
  logic [TIMER_W-1:0] r_timer;
`endif

  assign ready_o      = (r_state == ST_IDLE);
  assign w_accept     = valid_i & ready_o;
  assign w_isMem      = op_is_load(mem_op_i) | op_is_store(mem_op_i);
  assign w_misaligned = is_misaligned(mem_op_i, mem_addr_i[1:0]);

  mem_load_extend u_loadExtend (
    .i_rdata   (bus_rdata_i),
    .i_addrLsb (r_addrLsb),
    .i_op      (r_op),
    .o_data    (w_loadData)
  );

  // wb_valid/wb_we/misalign are pulses; bus address and data stay put after gnt.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_op        <= MEM_NOP;
      r_addrLsb   <= 2'd0;
      r_waddr     <= 5'd0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_be_o    <= 4'd0;
      wb_valid_o  <= 1'b0;
      wb_we_o     <= WRITE_DISABLE;
      wb_waddr_o  <= 5'd0;
      wb_wdata_o  <= '0;
      misalign_o  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err_o   <= 1'b0;
      r_timer     <= '0;
`endif
    end else begin
      wb_valid_o <= 1'b0;
      wb_we_o    <= WRITE_DISABLE;
      misalign_o <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err_o  <= 1'b0;
      if (r_state != ST_IDLE) begin
        r_timer <= r_timer + 1'b1;
      end
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (!w_isMem) begin
              wb_valid_o <= 1'b1;
              wb_we_o    <= reg_we_i;
              wb_waddr_o <= reg_waddr_i;
              wb_wdata_o <= reg_wdata_i;
            end else if (w_misaligned) begin
              wb_valid_o <= 1'b1;
              wb_waddr_o <= reg_waddr_i;
              misalign_o <= 1'b1;
            end else begin
              r_op        <= mem_op_i;
              r_addrLsb   <= mem_addr_i[1:0];
              r_waddr     <= reg_waddr_i;
              bus_req_o   <= 1'b1;
              bus_we_o    <= op_is_store(mem_op_i);
              bus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
              bus_wdata_o <= store_data(mem_op_i, mem_data_i);
              bus_be_o    <= byte_enable(mem_op_i, mem_addr_i[1:0]);
              r_state     <= ST_REQ;
`ifdef MEM_TIMEOUT_EN
              r_timer     <= '0;
`endif
            end
          end
        end

        ST_REQ: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            bus_be_o  <= 4'd0;
            if (op_is_store(r_op)) begin
              r_state    <= ST_IDLE;
              wb_valid_o <= 1'b1;
              wb_waddr_o <= r_waddr;
            end else begin
              r_state <= ST_RWAIT;
`ifdef MEM_TIMEOUT_EN
              r_timer <= '0;
`endif
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_timer == TIMER_MAX) begin
            bus_req_o  <= 1'b0;
            bus_we_o   <= 1'b0;
            bus_be_o   <= 4'd0;
            r_state    <= ST_IDLE;
            wb_valid_o <= 1'b1;
            wb_waddr_o <= r_waddr;
            bus_err_o  <= 1'b1;
          end
`endif
        end

        ST_RWAIT: begin
          if (bus_rvalid_i) begin
            r_state    <= ST_IDLE;
            wb_valid_o <= 1'b1;
            wb_we_o    <= WRITE_ENABLE;
            wb_waddr_o <= r_waddr;
            wb_wdata_o <= w_loadData;
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_timer == TIMER_MAX) begin
            r_state    <= ST_IDLE;
            wb_valid_o <= 1'b1;
            wb_waddr_o <= r_waddr;
            bus_err_o  <= 1'b1;
          end
`endif
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit: expected writeback beats are
// queued as each operation is issued and popped when the DUT emits a beat.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] reg_wdata_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        wb_valid_o;
  logic        wb_we_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic        misalign_o;
`ifdef MEM_TIMEOUT_EN
  logic        bus_err_o;
`endif

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        mis;
    logic        err;
  } wbExp_t;

  wbExp_t expQ[$];
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mem_access_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .mem_op_i     (mem_op_i),
    .mem_addr_i   (mem_addr_i),
    .mem_data_i   (mem_data_i),
    .reg_we_i     (reg_we_i),
    .reg_waddr_i  (reg_waddr_i),
    .reg_wdata_i  (reg_wdata_i),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_be_o     (bus_be_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_we_o      (wb_we_o),
    .wb_waddr_o   (wb_waddr_o),
    .wb_wdata_o   (wb_wdata_o),
    .misalign_o   (misalign_o)
`ifdef MEM_TIMEOUT_EN
    ,
    .bus_err_o    (bus_err_o)
`endif
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pushExpect(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                            input logic mis, input logic err);
    wbExp_t e;
    e.we = we;
    e.waddr = waddr;
    e.wdata = wdata;
    e.mis = mis;
    e.err = err;
    expQ.push_back(e);
  endtask

  // Presents one operation for a single cycle; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                               input logic we, input logic [4:0] waddr, input logic [31:0] wdata);
    valid_i = 1'b1;
    mem_op_i = op;
    mem_addr_i = addr;
    mem_data_i = data;
    reg_we_i = we;
    reg_waddr_i = waddr;
    reg_wdata_i = wdata;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    mem_op_i = MEM_NOP;
    reg_we_i = 1'b0;
  endtask

  // Checks the held request each cycle, grants after gntDelay cycles, and returns load data one cycle later.
  task automatic busRespond(input string tag, input logic isLoad, input logic [31:0] expAddr,
                            input logic [3:0] expBe, input logic [31:0] expWdata,
                            input int gntDelay, input logic [31:0] rdata);
    for (int i = 0; i <= gntDelay; i++) begin
      checkVal({tag, "_req"}, 32'(bus_req_o), 32'd1);
      checkVal({tag, "_busWe"}, 32'(bus_we_o), 32'(!isLoad));
      checkVal({tag, "_addr"}, bus_addr_o, expAddr);
      checkVal({tag, "_be"}, 32'(bus_be_o), 32'(expBe));
      if (!isLoad) checkVal({tag, "_wdata"}, bus_wdata_o, expWdata);
      checkVal({tag, "_busyReady"}, 32'(ready_o), 32'd0);
      if (i == gntDelay) bus_gnt_i = 1'b1;
      @(posedge clk_i); #1;
    end
    bus_gnt_i = 1'b0;
    checkVal({tag, "_reqDrop"}, 32'(bus_req_o), 32'd0);
    if (isLoad) begin
      checkVal({tag, "_rwaitReady"}, 32'(ready_o), 32'd0);
      bus_rvalid_i = 1'b1;
      bus_rdata_i = rdata;
      @(posedge clk_i); #1;
      bus_rvalid_i = 1'b0;
      bus_rdata_i = '0;
    end
  endtask

  task automatic checkOutput(input string tag, input int budget);
    int n = 0;
    wbExp_t e;
    while (!wb_valid_o && n < budget) begin
      @(posedge clk_i); #1;
      n++;
    end
    checkVal({tag, "_wbValid"}, 32'(wb_valid_o), 32'd1);
    if (wb_valid_o && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkVal({tag, "_wbWe"}, 32'(wb_we_o), 32'(e.we));
      if (e.we) begin
        checkVal({tag, "_wbWaddr"}, 32'(wb_waddr_o), 32'(e.waddr));
        checkVal({tag, "_wbWdata"}, wb_wdata_o, e.wdata);
      end
      checkVal({tag, "_misalign"}, 32'(misalign_o), 32'(e.mis));
`ifdef MEM_TIMEOUT_EN
      checkVal({tag, "_busErr"}, 32'(bus_err_o), 32'(e.err));
`endif
      checkVal({tag, "_beatReady"}, 32'(ready_o), 32'd1);
    end else if (wb_valid_o) begin
      checkVal({tag, "_unexpectedBeat"}, 32'(expQ.size()), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int reqCycles;
    valid_i = 1'b0;
    mem_op_i = MEM_NOP;
    mem_addr_i = '0;
    mem_data_i = '0;
    reg_we_i = 1'b0;
    reg_waddr_i = '0;
    reg_wdata_i = '0;
    bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i = '0;
    reqCycles = 0;

    repeat (3) @(posedge clk_i);
    #1;
    checkVal("rstReady", 32'(ready_o), 32'd1);
    checkVal("rstReq", 32'(bus_req_o), 32'd0);
    checkVal("rstBusWe", 32'(bus_we_o), 32'd0);
    checkVal("rstBe", 32'(bus_be_o), 32'd0);
    checkVal("rstAddr", bus_addr_o, 32'd0);
    checkVal("rstWbValid", 32'(wb_valid_o), 32'd0);
    checkVal("rstWbWdata", wb_wdata_o, 32'd0);
    checkVal("rstMisalign", 32'(misalign_o), 32'd0);
`ifdef MEM_TIMEOUT_EN
    checkVal("rstBusErr", 32'(bus_err_o), 32'd0);
`endif
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    pushExpect(1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0);
    applyStimulus(MEM_NOP, 32'h0, 32'h0, 1'b1, 5'd5, 32'h0000_1234);
    checkVal("nopNoReq", 32'(bus_req_o), 32'd0);
    checkOutput("nop", 0);

    pushExpect(1'b1, 5'd10, 32'hA5A5_0001, 1'b0, 1'b0);
    pushExpect(1'b0, 5'd11, 32'hA5A5_0002, 1'b0, 1'b0);
    applyStimulus(MEM_NOP, 32'h0, 32'h0, 1'b1, 5'd10, 32'hA5A5_0001);
    checkOutput("b2bFirst", 0);
    applyStimulus(MEM_NOP, 32'h0, 32'h0, 1'b0, 5'd11, 32'hA5A5_0002);
    checkOutput("b2bSecond", 0);

    pushExpect(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    applyStimulus(MEM_SB, 32'h0000_1003, 32'h0000_00AB, 1'b0, 5'd0, 32'h0);
    busRespond("sb", 1'b0, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 2, 32'h0);
    checkOutput("sb", 0);

    pushExpect(1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 1'b0);
    applyStimulus(MEM_LB, 32'h0000_2001, 32'h0, 1'b0, 5'd7, 32'h0);
    busRespond("lb", 1'b1, 32'h0000_2000, 4'b0010, 32'h0, 0, 32'h0000_8000);
    checkOutput("lb", 0);

    pushExpect(1'b1, 5'd8, 32'h0000_0080, 1'b0, 1'b0);
    applyStimulus(MEM_LBU, 32'h0000_2001, 32'h0, 1'b0, 5'd8, 32'h0);
    busRespond("lbu", 1'b1, 32'h0000_2000, 4'b0010, 32'h0, 0, 32'h0000_8000);
    checkOutput("lbu", 0);

    pushExpect(1'b1, 5'd9, 32'hFFFF_8001, 1'b0, 1'b0);
    applyStimulus(MEM_LH, 32'h0000_2002, 32'h0, 1'b0, 5'd9, 32'h0);
    busRespond("lh", 1'b1, 32'h0000_2000, 4'b1100, 32'h0, 1, 32'h8001_0000);
    checkOutput("lh", 0);

    pushExpect(1'b0, 5'd3, 32'h0, 1'b1, 1'b0);
    applyStimulus(MEM_LW, 32'h0000_2003, 32'h0, 1'b0, 5'd3, 32'h0);
    checkVal("lwMisNoReq", 32'(bus_req_o), 32'd0);
    checkOutput("lwMis", 0);

    pushExpect(1'b0, 5'd4, 32'h0, 1'b1, 1'b0);
    applyStimulus(MEM_SH, 32'h0000_3001, 32'h0000_BEEF, 1'b0, 5'd4, 32'h0);
    checkVal("shMisNoReq", 32'(bus_req_o), 32'd0);
    checkOutput("shMis", 0);

    pushExpect(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    applyStimulus(MEM_SH, 32'h0000_3002, 32'h1234_BEEF, 1'b0, 5'd0, 32'h0);
    busRespond("sh", 1'b0, 32'h0000_3000, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0);
    checkOutput("sh", 0);

    pushExpect(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    applyStimulus(MEM_SW, 32'h0000_3004, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
    busRespond("sw", 1'b0, 32'h0000_3004, 4'b1111, 32'hDEAD_BEEF, 1, 32'h0);
    checkOutput("sw", 0);

    pushExpect(1'b1, 5'd12, 32'h0000_F00D, 1'b0, 1'b0);
    applyStimulus(MEM_LHU, 32'h0000_2000, 32'h0, 1'b0, 5'd12, 32'h0);
    busRespond("lhu", 1'b1, 32'h0000_2000, 4'b0011, 32'h0, 0, 32'h1234_F00D);
    checkOutput("lhu", 0);

    pushExpect(1'b1, 5'd31, 32'hCAFE_BABE, 1'b0, 1'b0);
    applyStimulus(MEM_LW, 32'h0000_2004, 32'h0, 1'b0, 5'd31, 32'h0);
    busRespond("lw", 1'b1, 32'h0000_2004, 4'b1111, 32'h0, 1, 32'hCAFE_BABE);
    checkOutput("lw", 0);

    // Reset while a load waits for data; the late rvalid must be ignored.
    applyStimulus(MEM_LW, 32'h0000_2008, 32'h0, 1'b0, 5'd9, 32'h0);
    bus_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    bus_gnt_i = 1'b0;
    checkVal("midRstRwaitReady", 32'(ready_o), 32'd0);
    #2 rst_n_i = 1'b0;
    #1;
    checkVal("midRstReq", 32'(bus_req_o), 32'd0);
    checkVal("midRstAddr", bus_addr_o, 32'd0);
    checkVal("midRstWbWdata", wb_wdata_o, 32'd0);
    checkVal("midRstWbValid", 32'(wb_valid_o), 32'd0);
    checkVal("midRstReady", 32'(ready_o), 32'd1);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk_i); #1;
    bus_rvalid_i = 1'b0;
    bus_rdata_i = '0;
    checkVal("lateRvalidNoBeat", 32'(wb_valid_o), 32'd0);
    @(posedge clk_i); #1;
    checkVal("lateRvalidNoBeat2", 32'(wb_valid_o), 32'd0);
    checkVal("postRstReady", 32'(ready_o), 32'd1);

    pushExpect(1'b1, 5'd6, 32'h0BAD_F00D, 1'b0, 1'b0);
    applyStimulus(MEM_NOP, 32'h0, 32'h0, 1'b1, 5'd6, 32'h0BAD_F00D);
    checkOutput("postRstNop", 0);

`ifdef MEM_TIMEOUT_EN
    pushExpect(1'b0, 5'd1, 32'h0, 1'b0, 1'b1);
    applyStimulus(MEM_SW, 32'h0000_4000, 32'h0000_0055, 1'b0, 5'd1, 32'h0);
    while (bus_req_o && reqCycles < 10) begin
      reqCycles++;
      @(posedge clk_i); #1;
    end
    checkVal("timeoutReqCycles", 32'(reqCycles), 32'd4);
    checkOutput("timeout", 0);
`endif

    checkVal("sbDrained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
